uart_sector_packer: RTL and testbench

UART_SECTOR_PACKER -- requirements
Module: uart_sector_packer

---
 rtl/uart_sector_packer.sv | 140 ++++++++++++++
 tb/tb_uart_sector_packer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_sector_packer.sv
// UART byte stream to SD sector packer: two sector banks filled alternately,
// flushed on fill or idle timeout, and handed one at a time to the SD writer.
module uart_sector_packer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter logic [31:0] START_SECTOR   = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    input  logic        wr_busy,
    input  logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        overflow,
    output logic [31:0] sector_cnt
);
    localparam int IW = $clog2(SECTOR_BYTES);
    localparam int LW = $clog2(SECTOR_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SECTOR_BYTES - 1);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_nx;

    logic [7:0]           mem [2][SECTOR_BYTES];
    logic [1:0]           bank_full;
    logic [1:0][LW-1:0]   bank_len;
    logic                 fill_act, fill_bank, issue_ptr;
    logic [IW-1:0]        fill_cnt, rd_idx;
    logic [31:0]          to_cnt;

    logic          release_bank, can_fill, tgt, other, wr_byte;
    logic          timeout_hit, close_bank, other_empty, rd_en;
    logic [LW-1:0] close_len;

    // Banks fill and drain in strict alternation from bank 0, so the oldest
    // FULL bank is always issue_ptr and a released bank is issue_ptr too.
    always_comb begin
        release_bank = (state == WAIT_DONE) && !wr_busy;
        can_fill     = fill_act || release_bank;
        tgt          = fill_act ? fill_bank : issue_ptr;
        other        = ~tgt;
        wr_byte      = rx_valid && can_fill;
        timeout_hit  = (TIMEOUT_CYCLES != 0) && (fill_cnt != '0) && (to_cnt == TO_LAST);
        close_bank   = (wr_byte && fill_cnt == LAST_IDX) || timeout_hit;
        close_len    = LW'(fill_cnt) + LW'(wr_byte);
        other_empty  = !bank_full[other] || (release_bank && issue_ptr == other);
        rd_en        = wr_en && (state == WAIT_BUSY || state == WAIT_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bank_full  <= '0;
            bank_len   <= '0;
            fill_act   <= 1'b1;
            fill_bank  <= 1'b0;
            issue_ptr  <= 1'b0;
            fill_cnt   <= '0;
            to_cnt     <= '0;
            overflow   <= 1'b0;
            sector_cnt <= '0;
        end else begin
            if (release_bank) begin
                bank_full[issue_ptr] <= 1'b0;
                issue_ptr            <= ~issue_ptr;
                sector_cnt           <= sector_cnt + 32'd1;
                if (!fill_act) begin
                    fill_act  <= 1'b1;
                    fill_bank <= issue_ptr;
                end
            end
            if (rx_valid && !can_fill)
                overflow <= 1'b1;
            if (wr_byte)
                fill_cnt <= fill_cnt + 1'b1;
            if (rx_valid || fill_cnt == '0 || TIMEOUT_CYCLES == 0)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 32'd1;
            // Closing wins over the increments above; filling moves on only
            // if the other bank is (or is just becoming) empty.
            if (close_bank) begin
                bank_full[tgt] <= 1'b1;
                bank_len[tgt]  <= close_len;
                fill_cnt       <= '0;
                to_cnt         <= '0;
                fill_act       <= other_empty;
                fill_bank      <= other;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_byte)
            mem[tgt][fill_cnt] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_req   = 1'b0;
        case (state)
            IDLE:      if (bank_full[issue_ptr]) state_nx = REQ;
            REQ: begin
                wr_req   = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: if (wr_busy)  state_nx = WAIT_DONE;
            WAIT_DONE: if (!wr_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            rd_idx  <= '0;
        end else begin
            if (state == IDLE && bank_full[issue_ptr])
                wr_addr <= START_SECTOR + sector_cnt;
            if (state == REQ)
                rd_idx <= '0;
            if (rd_en) begin
                wr_data <= (LW'(rd_idx) < bank_len[issue_ptr]) ? mem[issue_ptr][rd_idx] : PAD_BYTE;
                rd_idx  <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_sector_packer.sv
// Directed-sequence bench for uart_sector_packer with random payloads checked
// against a stream-level model of pending sectors.
module tb_uart_sector_packer;
    localparam int          SB    = 512;
    localparam logic [31:0] START = 32'd100;
    localparam int          T     = 100;
    localparam logic [7:0]  PAD   = 8'hEE;

    logic        sys_clk = 1'b0, sys_rst = 1'b1, rx_valid = 1'b0, wr_busy = 1'b0, wr_en = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        wr_req, overflow;
    logic [31:0] wr_addr, sector_cnt;
    logic [7:0]  wr_data;

    int tests = 0, fails = 0, req_cnt = 0, served = 0;

    // Model: a partial sector plus up to two closed sectors awaiting commit.
    logic [7:0]  cur_d [SB];
    int          cur_n = 0;
    logic [7:0]  pend_d [2][SB];
    int          pend_len [2];
    int          pend_n = 0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    uart_sector_packer #(
        .SECTOR_BYTES(SB), .START_SECTOR(START), .TIMEOUT_CYCLES(T), .PAD_BYTE(PAD)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_busy(wr_busy), .wr_en(wr_en),
        .wr_data(wr_data), .overflow(overflow), .sector_cnt(sector_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (wr_req) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_close();
        if (cur_n > 0 && pend_n < 2) begin
            for (int i = 0; i < SB; i++) pend_d[pend_n][i] = cur_d[i];
            pend_len[pend_n] = cur_n;
            pend_n++;
            cur_n = 0;
        end
    endtask

    task automatic m_push(input logic [7:0] b);
        if (pend_n < 2) begin
            cur_d[cur_n] = b;
            cur_n++;
            if (cur_n == SB) m_close();
        end else
            m_ovf = 1'b1;
    endtask

    task automatic m_commit();
        if (pend_n > 0) begin
            for (int i = 0; i < SB; i++) pend_d[0][i] = pend_d[1][i];
            pend_len[0] = pend_len[1];
            pend_n--;
            m_cnt++;
        end
    endtask

    task automatic m_reset();
        cur_n = 0; pend_n = 0; m_ovf = 1'b0; m_cnt = 32'd0;
    endtask

    // Called right after a negedge; returns right after the next one.
    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        m_push(b);
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input int i);
        logic [7:0] exp;
        exp = (i < pend_len[0]) ? pend_d[0][i] : PAD;
        wr_en = 1'b1;
        @(negedge sys_clk);
        wr_en = 1'b0;
        chk(tag, 32'(wr_data), 32'(exp));
    endtask

    // Act as the SD writer for one sector; optionally land a byte on the
    // same cycle the bank is released.
    task automatic serve(input string tag, input bit co, input logic [7:0] cb);
        for (int k = 0; k < 3000 && req_cnt <= served; k++) @(negedge sys_clk);
        chk({tag, "_req"}, 32'(req_cnt > served), 32'd1);
        served++;
        chk({tag, "_addr"}, wr_addr, START + m_cnt);
        wr_busy = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < SB; i++) read_check({tag, "_data"}, i);
        wr_busy = 1'b0;
        if (co) begin rx_data = cb; rx_valid = 1'b1; end
        @(negedge sys_clk);
        rx_valid = 1'b0;
        m_commit();
        if (co) m_push(cb);
        chk({tag, "_cnt"}, sector_cnt, m_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, k;
        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_sector_cnt", sector_cnt, 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // One full sector of an incrementing pattern
        r0 = req_cnt;
        for (int i = 0; i < SB; i++) send(8'(i));
        repeat (4) @(negedge sys_clk);
        chk("inc_one_req", 32'(req_cnt - r0), 32'd1);
        serve("inc", 1'b0, 8'h00);

        // Two random sectors with short gaps, served after both are full
        for (int i = 0; i < 2 * SB; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge sys_clk);
        end
        serve("rnd_a", 1'b0, 8'h00);
        serve("rnd_b", 1'b0, 8'h00);
        chk("three_sectors", sector_cnt, 32'd3);

        // Idle timeout flush of a short sector
        for (int i = 0; i < 10; i++) send(8'hA5);
        for (k = 1; k <= T + 20; k++) begin
            @(negedge sys_clk);
            if (wr_req) break;
        end
        chk("timeout_latency", 32'(k), 32'(T + 1));
        m_close();
        serve("timeout", 1'b0, 8'h00);

        // Byte landing on the timeout cycle is kept in the flushed sector
        send(8'h11); send(8'h22); send(8'h33);
        repeat (T - 1) @(negedge sys_clk);
        send(8'h44);
        m_close();
        serve("to_coinc", 1'b0, 8'h00);

        // Overflow with the writer stalled busy
        chk("ovf_clear", 32'(overflow), 32'd0);
        wr_busy = 1'b1;
        r0 = req_cnt;
        for (int i = 0; i < 3 * SB; i++) send(8'($urandom));
        repeat (4) @(negedge sys_clk);
        chk("ovf_set", 32'(overflow), 32'(m_ovf));
        chk("ovf_one_req", 32'(req_cnt - r0), 32'd1);
        serve("ovf0", 1'b1, 8'h5C);
        for (int i = 1; i < SB; i++) send(8'($urandom));
        serve("ovf1", 1'b0, 8'h00);
        serve("ovf2", 1'b0, 8'h00);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a sector write
        for (int i = 0; i < SB; i++) send(8'($urandom));
        for (k = 0; k < 100 && req_cnt <= served; k++) @(negedge sys_clk);
        wr_busy = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 5; i++) read_check("mid_data", i);
        for (int i = 0; i < 20; i++) send(8'($urandom));
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_wr_req", 32'(wr_req), 32'd0);
        chk("mid_rst_wr_addr", wr_addr, 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_sector_cnt", sector_cnt, 32'd0);
        sys_rst = 1'b0;
        m_reset();
        r0 = req_cnt;
        repeat (10) @(negedge sys_clk);
        wr_busy = 1'b0;
        repeat (3 * T) @(negedge sys_clk);
        chk("post_rst_no_req", 32'(req_cnt - r0), 32'd0);
        served = req_cnt;
        for (int i = 0; i < SB; i++) send(8'($urandom));
        serve("post_rst", 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
